// File: rtl/lane_mux_2x1_8bits.sv
// Two-lane byte merger: per-lane FIFOs feed a strict lane0/lane1 alternating
// output stream; a lane that is empty stalls the merge rather than being skipped.
module lane_mux_2x1_8bits #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic [WIDTH-1:0] data_in0,
    input  logic             valid_in0,
    output logic             ready0,
    input  logic [WIDTH-1:0] data_in1,
    input  logic             valid_in1,
    output logic             ready1,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             err_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [WIDTH-1:0] mem0_q [DEPTH];
    logic [WIDTH-1:0] mem1_q [DEPTH];
    logic [AW-1:0]    wr_ptr0_q, rd_ptr0_q, wr_ptr1_q, rd_ptr1_q;
    logic [CW-1:0]    cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic             sel_q;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             valid_out_q;
    logic             err_ovf_q, err_ovf_d;

    logic             wr0, wr1, rd0, rd1, ovf;
    logic [WIDTH-1:0] head;

    // Read decision uses the pre-edge count, so a byte is never emitted on the edge it is written.
    always_comb begin
        wr0  = valid_in0 && (cnt0_q != FULL);
        wr1  = valid_in1 && (cnt1_q != FULL);
        ovf  = (valid_in0 && (cnt0_q == FULL)) || (valid_in1 && (cnt1_q == FULL));
        rd0  = !sel_q && (cnt0_q != '0);
        rd1  =  sel_q && (cnt1_q != '0);
        head = sel_q ? mem1_q[rd_ptr1_q] : mem0_q[rd_ptr0_q];

        cnt0_d = cnt0_q;
        if (wr0 && !rd0) cnt0_d = cnt0_q + CNT_ONE;
        if (!wr0 && rd0) cnt0_d = cnt0_q - CNT_ONE;

        cnt1_d = cnt1_q;
        if (wr1 && !rd1) cnt1_d = cnt1_q + CNT_ONE;
        if (!wr1 && rd1) cnt1_d = cnt1_q - CNT_ONE;

        data_out_d = (rd0 || rd1) ? head : data_out_q;
        err_ovf_d  = err_ovf_q || ovf;
    end

    always_ff @(posedge clk) begin
        if (wr0) mem0_q[wr_ptr0_q] <= data_in0;
        if (wr1) mem1_q[wr_ptr1_q] <= data_in1;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr0_q   <= '0;
            rd_ptr0_q   <= '0;
            wr_ptr1_q   <= '0;
            rd_ptr1_q   <= '0;
            cnt0_q      <= '0;
            cnt1_q      <= '0;
            sel_q       <= 1'b0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            if (wr0) wr_ptr0_q <= wr_ptr0_q + PTR_ONE;
            if (wr1) wr_ptr1_q <= wr_ptr1_q + PTR_ONE;
            if (rd0) rd_ptr0_q <= rd_ptr0_q + PTR_ONE;
            if (rd1) rd_ptr1_q <= rd_ptr1_q + PTR_ONE;
            cnt0_q      <= cnt0_d;
            cnt1_q      <= cnt1_d;
            if (rd0 || rd1) sel_q <= ~sel_q;
            data_out_q  <= data_out_d;
            valid_out_q <= rd0 || rd1;
            err_ovf_q   <= err_ovf_d;
        end
    end

    // Upstream is held off for the whole time reset is asserted.
    assign ready0    = reset_L && (cnt0_q != FULL);
    assign ready1    = reset_L && (cnt1_q != FULL);
    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;
    assign err_ovf   = err_ovf_q;
endmodule
